if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 185 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding an IF/ID pipeline register. It issues one
//   request per word to a ready/valid-style instruction memory and absorbs
//   decode stalls with a one-entry skid buffer. Redirects are handled without
//   a delay slot: a redirect that lands while a response is still outstanding
//   is remembered in redir_pc until that response can be thrown away.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-high reset
//   shouldStall         decode holds its instruction this cycle
//   shouldJumpOrBranch  decode requests a redirect (ignored while stalled)
//   jumpOrBranchPc      redirect target (low two bits are dropped)
//   imem_req            request valid towards instruction memory
//   imem_addr           word-aligned byte address of the request (= pc)
//   imem_ready          imem_data is valid for the outstanding request
//   imem_data           fetched instruction word
//   instruction         IF/ID instruction register
//   pc_4                IF/ID fetch address + 4
//   id_valid            IF/ID holds a real fetched word (0 = bubble)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [31:0] pc_4,
  output logic        id_valid
);

  // REQ  : request outstanding at pc, response is wanted
  // HELD : a word sits in the skid buffer because decode stalled; no request
  // DRAIN: request outstanding at pc but its response must be discarded
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HELD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // A redirect only counts when decode is not stalled.
  assign redirect  = shouldJumpOrBranch & ~shouldStall;
  assign target    = jumpOrBranchPc & 32'hFFFF_FFFC;
  assign pc_plus4  = pc_q + 32'd4;   // wraps modulo 2^32

  // The request is gated by rst so it is low for the whole reset interval.
  assign imem_req    = ~rst & (state_q != ST_HELD);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign pc_4        = pc4_q;
  assign id_valid    = valid_q;

  // Next-state logic for the fetch FSM, pc, skid buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    redir_pc_d   = redir_pc_q;

    // IF/ID defaults to a bubble whenever decode can take something; the
    // cases below overwrite it when a real word is delivered.
    if (!shouldStall) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end

    case (state_q)
      ST_REQ: begin
        if (imem_ready) begin
          if (shouldStall) begin
            // Decode cannot take the word: park it and stop requesting.
            skid_instr_d = imem_data;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = ST_HELD;
          end else if (redirect) begin
            // Word fetched this cycle is on the wrong path: drop it.
            pc_d = target;
          end else begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          // Address must stay put until the response arrives, so a redirect
          // is deferred and the in-flight response will be drained.
          if (redirect) begin
            redir_pc_d = target;
            state_d    = ST_DRAIN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_HELD: begin
        if (!shouldStall) begin
          state_d = ST_REQ;
          if (redirect) begin
            pc_d = target;
          end else begin
            instr_d = skid_instr_q;
            pc4_d   = skid_pc4_q;
            valid_d = 1'b1;
          end
        end else begin
          state_d = ST_HELD;
        end
      end

      ST_DRAIN: begin
        // The latest honoured redirect wins, including one in the same
        // cycle the stale response finally returns.
        if (redirect) begin
          redir_pc_d = target;
        end else begin
          redir_pc_d = redir_pc_q;
        end
        if (imem_ready) begin
          pc_d    = redirect ? target : redir_pc_q;
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      skid_instr_q <= 32'h0000_0000;
      skid_pc4_q   <= 32'h0000_0000;
      redir_pc_q   <= 32'h0000_0000;
      instr_q      <= NOP_WORD;
      pc4_q        <= 32'h0000_0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      redir_pc_q   <= redir_pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed scenarios with fixed expected values plus a randomized run
//   compared against a behavioural fetch model. Instruction memory returns
//   address ^ KEY for every word.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY         = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpOrBranchPc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instruction;
  logic [31:0] pc_4;
  logic        id_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  if_fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_WORD(TB_NOP)) dut (
    .clk(clk), .rst(rst),
    .shouldStall(shouldStall), .shouldJumpOrBranch(shouldJumpOrBranch),
    .jumpOrBranchPc(jumpOrBranchPc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .instruction(instruction), .pc_4(pc_4), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // The fetcher is described as: the address being fetched, a queue of words
  // decode has not yet taken, and whether the outstanding response is stale
  // (plus where to go once it is gone).
  logic [31:0] m_pc, m_instr, m_pc4, m_stale_tgt;
  logic        m_valid, m_stale;
  logic [63:0] m_held[$];

  task automatic model_reset();
    m_pc = TB_RESET_PC; m_instr = TB_NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    m_held.delete(); m_stale = 1'b0; m_stale_tgt = 32'h0;
  endtask

  task automatic model_step(input logic st, input logic jb,
                            input logic [31:0] tgt, input logic rdy);
    logic        honour, got;
    logic [31:0] dest, word, next_addr;
    honour    = jb && !st;
    dest      = tgt & 32'hFFFF_FFFC;
    word      = m_pc ^ KEY;
    next_addr = m_pc + 32'd4;
    got       = (m_held.size() == 0) && rdy;
    // what decode sees next
    if (!st) begin
      m_instr = TB_NOP; m_pc4 = 32'h0; m_valid = 1'b0;
      if (m_held.size() != 0) begin
        if (!honour) begin
          m_instr = m_held[0][63:32]; m_pc4 = m_held[0][31:0]; m_valid = 1'b1;
        end
      end else if (got && !m_stale && !honour) begin
        m_instr = word; m_pc4 = next_addr; m_valid = 1'b1;
      end
    end
    // where fetching goes next
    if (m_held.size() != 0) begin
      if (!st) begin
        void'(m_held.pop_front());
        if (honour) m_pc = dest;
      end
    end else if (m_stale) begin
      if (honour) m_stale_tgt = dest;
      if (rdy) begin m_pc = m_stale_tgt; m_stale = 1'b0; end
    end else if (rdy) begin
      if (st) begin m_held.push_back({word, next_addr}); m_pc = next_addr; end
      else if (honour) m_pc = dest;
      else m_pc = next_addr;
    end else if (honour) begin
      m_stale = 1'b1; m_stale_tgt = dest;
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick(input logic st, input logic jb,
                      input logic [31:0] tgt, input logic rdy);
    shouldStall = st; shouldJumpOrBranch = jb; jumpOrBranchPc = tgt;
    imem_ready = rdy; imem_data = imem_addr ^ KEY;
    model_step(st, jb, tgt, rdy);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc = 32'h0; imem_ready = 1'b0; imem_data = 32'h0;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++; if (instruction !== TB_NOP) begin tests_failed++; $display("FAIL reset_instr: got %h expected %h", instruction, TB_NOP); end
    tests_run++; if (pc_4 !== 32'h0) begin tests_failed++; $display("FAIL reset_pc4: got %h expected 0", pc_4); end
    tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    rst = 1'b0; model_reset();
    #1;
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b expected 1", imem_req); end
    tests_run++; if (imem_addr !== TB_RESET_PC) begin tests_failed++; $display("FAIL first_addr: got %h expected %h", imem_addr, TB_RESET_PC); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tests_run++;
      if (instruction !== ((32'(i) * 32'd4) ^ KEY) || pc_4 !== 32'(i + 1) * 32'd4 || id_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream[%0d]: got %h/%h/%b expected %h/%h/1", i, instruction, pc_4, id_valid,
                 (32'(i) * 32'd4) ^ KEY, 32'(i + 1) * 32'd4);
      end
    end
  endtask

  task automatic test_stall_held();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);   // word 0x10 returns while stalled
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (instruction !== (32'h0C ^ KEY) || pc_4 !== 32'h10 || id_valid !== 1'b1 || imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL held_freeze[%0d]: got %h/%h/%b req %b expected %h/00000010/1 req 0",
                 i, instruction, pc_4, id_valid, imem_req, 32'h0C ^ KEY);
      end
      if (i < 2) tick(1'b1, 1'b0, 32'h0, 1'b0);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (instruction !== (32'h10 ^ KEY) || pc_4 !== 32'h14 || id_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      tests_failed++;
      $display("FAIL held_release: got %h/%h/%b req %b addr %h expected %h/00000014/1 req 1 addr 00000014",
               instruction, pc_4, id_valid, imem_req, imem_addr, 32'h10 ^ KEY);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (instruction !== (32'h14 ^ KEY) || pc_4 !== 32'h18) begin
      tests_failed++;
      $display("FAIL held_next: got %h/%h expected %h/00000018", instruction, pc_4, 32'h14 ^ KEY);
    end
  endtask

  task automatic test_redirect_ready();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    tests_run++;
    if (imem_addr !== 32'h100 || id_valid !== 1'b0 || instruction !== TB_NOP || pc_4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL redir_ready: got addr %h %h/%h/%b expected addr 00000100 %h/00000000/0",
               imem_addr, instruction, pc_4, id_valid, TB_NOP);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (instruction !== (32'h100 ^ KEY) || pc_4 !== 32'h104 || id_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL redir_target_word: got %h/%h/%b expected %h/00000104/1", instruction, pc_4, id_valid, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, (i == 0) ? 1'b1 : 1'b0, 32'h200, 1'b0);
      tests_run++;
      if (imem_addr !== 32'h8 || imem_req !== 1'b1 || id_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL drain_hold[%0d]: got addr %h req %b valid %b expected addr 00000008 req 1 valid 0",
                 i, imem_addr, imem_req, id_valid);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (imem_addr !== 32'h200 || id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_discard: got addr %h valid %b expected addr 00000200 valid 0", imem_addr, id_valid);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (instruction !== (32'h200 ^ KEY) || pc_4 !== 32'h204 || id_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_target_word: got %h/%h/%b expected %h/00000204/1", instruction, pc_4, id_valid, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_stall_and_jump();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b1, 32'h300, 1'b1);
    tests_run++;
    if (imem_addr !== 32'hC || instruction !== (32'h4 ^ KEY) || pc_4 !== 32'h8 || id_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_jump_hold: got addr %h %h/%h/%b expected addr 0000000c %h/00000008/1",
               imem_addr, instruction, pc_4, id_valid, 32'h4 ^ KEY);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tests_run++;
    if (imem_addr !== 32'hC || instruction !== (32'h8 ^ KEY) || pc_4 !== 32'hC) begin
      tests_failed++;
      $display("FAIL stall_jump_next: got addr %h %h/%h expected addr 0000000c %h/0000000c",
               imem_addr, instruction, pc_4, 32'h8 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    tests_run++;
    if (imem_addr !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (instruction !== (32'hFFFF_FFFC ^ KEY) || pc_4 !== 32'h0 || id_valid !== 1'b1 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap: got %h/%h/%b addr %h expected %h/00000000/1 addr 00000000",
               instruction, pc_4, id_valid, imem_addr, 32'hFFFF_FFFC ^ KEY);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h200, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || imem_addr !== TB_RESET_PC || id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rst: got req %b addr %h valid %b expected req 0 addr %h valid 0",
               imem_req, imem_addr, id_valid, TB_RESET_PC);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0; model_reset();
    #1;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    tests_run++;
    if (instruction !== (TB_RESET_PC ^ KEY) || pc_4 !== TB_RESET_PC + 32'd4 || id_valid !== 1'b1 || imem_addr !== TB_RESET_PC + 32'd4) begin
      tests_failed++;
      $display("FAIL rst_drain_restart: got %h/%h/%b addr %h expected %h/%h/1 addr %h",
               instruction, pc_4, id_valid, imem_addr, TB_RESET_PC ^ KEY, TB_RESET_PC + 32'd4, TB_RESET_PC + 32'd4);
    end
  endtask

  task automatic test_random();
    logic exp_req;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15, $urandom(), $urandom_range(0, 99) < 60);
      exp_req = (m_held.size() == 0);
      tests_run++;
      if (imem_req !== exp_req || imem_addr !== m_pc || instruction !== m_instr || pc_4 !== m_pc4 || id_valid !== m_valid) begin
        tests_failed++;
        $display("FAIL random[%0d]: got req %b addr %h %h/%h/%b expected req %b addr %h %h/%h/%b",
                 i, imem_req, imem_addr, instruction, pc_4, id_valid, exp_req, m_pc, m_instr, m_pc4, m_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc = 32'h0; imem_ready = 1'b0; imem_data = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall_held();
    test_redirect_ready();
    test_redirect_drain();
    test_stall_and_jump();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
